// File: rtl/cpu_types_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | cpu_types_pkg                                                      |
// | Datapath-wide scalar types shared across the CPU.                  |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
package cpu_types_pkg;

    localparam int c_WORD_W = 32;

    typedef logic [c_WORD_W-1:0] word_t;

endpackage
`default_nettype wire

// File: rtl/diaosi_types_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | diaosi_types_pkg                                                   |
// | PC source select and fetch-sequencer state encodings.              |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
package diaosi_types_pkg;

    typedef enum logic [1:0] {
        PC_NPC = 2'd0,
        PC_BR  = 2'd1,
        PC_J   = 2'd2,
        PC_JR  = 2'd3
    } PCSrc_t;

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        REDIR  = 2'd1,
        HALTED = 2'd2
    } fetch_state_t;

    function automatic logic is_redirect(input PCSrc_t src);
        return (src != PC_NPC);
    endfunction

endpackage
`default_nettype wire

// File: rtl/pc_fetch_ctrl_if.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | pc_fetch_ctrl_if                                                   |
// | Bundle between the fetch sequencer and its cache/hazard/PC peers.  |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
interface pc_fetch_ctrl_if #(
    parameter int CNT_W = 16
);

    logic                         ihit;
    logic                         stall;
    logic                         halt;
    logic                         redir_req;
    diaosi_types_pkg::PCSrc_t     redir_src;
    logic [15:0]                  redir_imm16;
    logic [25:0]                  redir_addr26;
    cpu_types_pkg::word_t         redir_jr;

    logic                         pc_next;
    diaosi_types_pkg::PCSrc_t     PCSrc;
    logic [15:0]                  imm16;
    logic [25:0]                  j_addr26;
    cpu_types_pkg::word_t         jr;
    logic                         iREN;
    logic                         squash;
    logic                         halted;
    logic [CNT_W-1:0]             fetch_cnt;
    logic [CNT_W-1:0]             redir_cnt;

    // master: the fetch sequencer itself
    modport master (
        input  ihit, stall, halt, redir_req, redir_src, redir_imm16,
               redir_addr26, redir_jr,
        output pc_next, PCSrc, imm16, j_addr26, jr, iREN, squash, halted,
               fetch_cnt, redir_cnt
    );

    // slave: the surrounding pipeline that feeds it and consumes its outputs
    modport slave (
        output ihit, stall, halt, redir_req, redir_src, redir_imm16,
               redir_addr26, redir_jr,
        input  pc_next, PCSrc, imm16, j_addr26, jr, iREN, squash, halted,
               fetch_cnt, redir_cnt
    );

endinterface
`default_nettype wire

// File: rtl/sat_counter.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | sat_counter                                                        |
// | Up-counter that sticks at all-ones instead of wrapping.            |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module sat_counter #(
    parameter int W = 16
) (
    input  logic         CLK,
    input  logic         nRST,
    input  logic         inc,
    output logic [W-1:0] count
);

    localparam logic [W-1:0] c_MAX = {W{1'b1}};
    localparam logic [W-1:0] c_ONE = {{(W-1){1'b0}}, 1'b1};

    logic [W-1:0] r_count;

    always_ff @(posedge CLK) begin
        if (!nRST) begin
            r_count <= '0;
        end else if (inc && (r_count != c_MAX)) begin
            r_count <= r_count + c_ONE;
        end
    end

    assign count = r_count;

endmodule
`default_nettype wire

// File: rtl/pc_fetch_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | pc_fetch_ctrl                                                      |
// | Fetch sequencer: PC advance/source select, deferred redirect, halt.|
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module pc_fetch_ctrl
    import cpu_types_pkg::*;
    import diaosi_types_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic            CLK,
    input  logic            nRST,
    pc_fetch_ctrl_if.master bus
);

    fetch_state_t r_state;
    PCSrc_t       r_pend_src;
    logic [15:0]  r_pend_imm16;
    logic [25:0]  r_pend_addr26;
    word_t        r_pend_jr;
    logic         r_halted;

    logic         w_adv;
    logic         w_pc_next;
    PCSrc_t       w_src;
    logic [15:0]  w_imm16;
    logic [25:0]  w_addr26;
    word_t        w_jr;
    logic         w_iren;
    logic         w_squash;
    logic         w_redir_inc;

    logic [CNT_W-1:0] w_fetch_cnt;
    logic [CNT_W-1:0] w_redir_cnt;

    assign w_adv = bus.ihit & ~bus.stall;

    always_ff @(posedge CLK) begin
        if (!nRST) begin
            r_state       <= RUN;
            r_pend_src    <= PC_NPC;
            r_pend_imm16  <= '0;
            r_pend_addr26 <= '0;
            r_pend_jr     <= '0;
            r_halted      <= 1'b0;
        end else begin
            case (r_state)
                RUN: begin
                    if (bus.halt) begin
                        r_state  <= HALTED;
                        r_halted <= 1'b1;
                    end else if (bus.redir_req && !w_adv) begin
                        // Fetch in flight has not completed; park the target.
                        r_state       <= REDIR;
                        r_pend_src    <= bus.redir_src;
                        r_pend_imm16  <= bus.redir_imm16;
                        r_pend_addr26 <= bus.redir_addr26;
                        r_pend_jr     <= bus.redir_jr;
                    end
                end
                REDIR: begin
                    if (bus.halt || w_adv) begin
                        r_state       <= bus.halt ? HALTED : RUN;
                        r_halted      <= bus.halt;
                        r_pend_src    <= PC_NPC;
                        r_pend_imm16  <= '0;
                        r_pend_addr26 <= '0;
                        r_pend_jr     <= '0;
                    end
                end
                HALTED: begin
                    r_state <= HALTED;
                end
                default: begin
                    r_state <= RUN;
                end
            endcase
        end
    end

    always_comb begin
        w_pc_next = 1'b0;
        w_src     = PC_NPC;
        w_imm16   = '0;
        w_addr26  = '0;
        w_jr      = '0;
        w_iren    = 1'b0;
        w_squash  = 1'b0;
        if (nRST) begin
            case (r_state)
                RUN: begin
                    w_iren = 1'b1;
                    // Halt outranks both a redirect and a normal advance.
                    if (!bus.halt) begin
                        if (bus.redir_req) begin
                            if (w_adv) begin
                                w_pc_next = 1'b1;
                                w_src     = bus.redir_src;
                                w_imm16   = bus.redir_imm16;
                                w_addr26  = bus.redir_addr26;
                                w_jr      = bus.redir_jr;
                                w_squash  = 1'b1;
                            end
                        end else begin
                            w_pc_next = w_adv;
                        end
                    end
                end
                REDIR: begin
                    w_iren = 1'b1;
                    if (!bus.halt) begin
                        w_pc_next = w_adv;
                        w_squash  = w_adv;
                        w_src     = r_pend_src;
                        w_imm16   = r_pend_imm16;
                        w_addr26  = r_pend_addr26;
                        w_jr      = r_pend_jr;
                    end
                end
                default: begin
                    w_iren = 1'b0;
                end
            endcase
        end
    end

    assign w_redir_inc = w_pc_next & is_redirect(w_src);

    sat_counter #(.W(CNT_W)) u_fetch_cnt (
        .CLK   (CLK),
        .nRST  (nRST),
        .inc   (w_pc_next),
        .count (w_fetch_cnt)
    );

    sat_counter #(.W(CNT_W)) u_redir_cnt (
        .CLK   (CLK),
        .nRST  (nRST),
        .inc   (w_redir_inc),
        .count (w_redir_cnt)
    );

    assign bus.pc_next   = w_pc_next;
    assign bus.PCSrc     = w_src;
    assign bus.imm16     = w_imm16;
    assign bus.j_addr26  = w_addr26;
    assign bus.jr        = w_jr;
    assign bus.iREN      = w_iren;
    assign bus.squash    = w_squash;
    assign bus.halted    = r_halted;
    assign bus.fetch_cnt = w_fetch_cnt;
    assign bus.redir_cnt = w_redir_cnt;

endmodule
`default_nettype wire

// File: tb/tb_pc_fetch_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_pc_fetch_ctrl                                                   |
// | Directed self-checking bench for the fetch sequencer (CNT_W = 4).  |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module tb_pc_fetch_ctrl;
    import cpu_types_pkg::*;
    import diaosi_types_pkg::*;

    localparam int c_CNT_W = 4;

    logic CLK;
    logic nRST;
    int   tests;
    int   fails;

    pc_fetch_ctrl_if #(.CNT_W(c_CNT_W)) bus ();

    pc_fetch_ctrl #(.CNT_W(c_CNT_W)) dut (
        .CLK  (CLK),
        .nRST (nRST),
        .bus  (bus)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Apply inputs 1 time unit after the rising edge, settle, then return.
    task automatic drive(input logic ihit, input logic stall, input logic halt,
                         input logic req, input PCSrc_t src, input logic [15:0] imm,
                         input logic [25:0] a26, input word_t jrv);
        bus.ihit         = ihit;
        bus.stall        = stall;
        bus.halt         = halt;
        bus.redir_req    = req;
        bus.redir_src    = src;
        bus.redir_imm16  = imm;
        bus.redir_addr26 = a26;
        bus.redir_jr     = jrv;
        #1;
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic chk_mealy(input string tag, input logic pcn, input PCSrc_t src,
                             input logic sq, input logic iren);
        chk({tag, ".pc_next"}, 32'(bus.pc_next), 32'(pcn));
        chk({tag, ".PCSrc"},   32'(bus.PCSrc),   32'(src));
        chk({tag, ".squash"},  32'(bus.squash),  32'(sq));
        chk({tag, ".iREN"},    32'(bus.iREN),    32'(iren));
    endtask

    initial begin
        tests = 0;
        fails = 0;
        nRST  = 1'b0;
        drive(1'b1, 1'b0, 1'b0, 1'b1, PC_BR, 16'h1234, 26'h1, 32'h55);
        chk_mealy("rst_force", 1'b0, PC_NPC, 1'b0, 1'b0);
        chk("rst_force.imm16", 32'(bus.imm16), 32'h0);
        tick();
        tick();
        chk("rst.halted",    32'(bus.halted),    32'h0);
        chk("rst.fetch_cnt", 32'(bus.fetch_cnt), 32'h0);
        chk("rst.redir_cnt", 32'(bus.redir_cnt), 32'h0);

        // Sequential fetch: 5 advances
        nRST = 1'b1;
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, 1'b0, 1'b0, 1'b0, PC_NPC, '0, '0, '0);
            chk_mealy("seq", 1'b1, PC_NPC, 1'b0, 1'b1);
            tick();
        end
        chk("seq.fetch_cnt", 32'(bus.fetch_cnt), 32'd5);
        chk("seq.redir_cnt", 32'(bus.redir_cnt), 32'd0);

        // Same-cycle branch redirect
        drive(1'b1, 1'b0, 1'b0, 1'b1, PC_BR, 16'h0004, '0, '0);
        chk_mealy("br", 1'b1, PC_BR, 1'b1, 1'b1);
        chk("br.imm16", 32'(bus.imm16), 32'h4);
        tick();
        chk("br.fetch_cnt", 32'(bus.fetch_cnt), 32'd6);
        chk("br.redir_cnt", 32'(bus.redir_cnt), 32'd1);
        drive(1'b1, 1'b0, 1'b0, 1'b0, PC_NPC, '0, '0, '0);
        chk_mealy("br_after", 1'b1, PC_NPC, 1'b0, 1'b1);
        chk("br_after.imm16", 32'(bus.imm16), 32'h0);
        tick();

        // Deferred JR redirect, with a wrong-path J request ignored
        drive(1'b0, 1'b0, 1'b0, 1'b1, PC_JR, '0, '0, 32'h0000_0100);
        chk_mealy("jr_req", 1'b0, PC_NPC, 1'b0, 1'b1);
        tick();
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, 1'b0, 1'b0, (i == 0), PC_J, '0, 26'h123, 32'hDEAD);
            chk_mealy("jr_wait", 1'b0, PC_JR, 1'b0, 1'b1);
            chk("jr_wait.jr", 32'(bus.jr), 32'h100);
            tick();
        end
        drive(1'b1, 1'b0, 1'b0, 1'b0, PC_NPC, '0, '0, '0);
        chk_mealy("jr_go", 1'b1, PC_JR, 1'b1, 1'b1);
        chk("jr_go.jr", 32'(bus.jr), 32'h100);
        tick();
        chk("jr_go.fetch_cnt", 32'(bus.fetch_cnt), 32'd8);
        chk("jr_go.redir_cnt", 32'(bus.redir_cnt), 32'd2);
        drive(1'b1, 1'b0, 1'b0, 1'b0, PC_NPC, '0, '0, '0);
        chk_mealy("jr_after", 1'b1, PC_NPC, 1'b0, 1'b1);
        chk("jr_after.jr", 32'(bus.jr), 32'h0);
        tick();

        // Redirect held under stall
        drive(1'b1, 1'b1, 1'b0, 1'b1, PC_J, '0, 26'h3ABCDE, '0);
        chk_mealy("j_req", 1'b0, PC_NPC, 1'b0, 1'b1);
        tick();
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 1'b1, 1'b0, 1'b0, PC_NPC, '0, '0, '0);
            chk_mealy("j_stall", 1'b0, PC_J, 1'b0, 1'b1);
            chk("j_stall.j_addr26", 32'(bus.j_addr26), 32'h3ABCDE);
            tick();
        end
        drive(1'b1, 1'b0, 1'b0, 1'b0, PC_NPC, '0, '0, '0);
        chk_mealy("j_go", 1'b1, PC_J, 1'b1, 1'b1);
        chk("j_go.j_addr26", 32'(bus.j_addr26), 32'h3ABCDE);
        tick();
        chk("j_go.fetch_cnt", 32'(bus.fetch_cnt), 32'd10);
        chk("j_go.redir_cnt", 32'(bus.redir_cnt), 32'd3);
        drive(1'b0, 1'b0, 1'b0, 1'b0, PC_NPC, '0, '0, '0);
        chk_mealy("j_after", 1'b0, PC_NPC, 1'b0, 1'b1);
        tick();

        // Halt beats redirect and advance
        drive(1'b1, 1'b0, 1'b1, 1'b1, PC_BR, 16'h8, '0, '0);
        chk("halt.pc_next", 32'(bus.pc_next), 32'h0);
        chk("halt.squash",  32'(bus.squash),  32'h0);
        tick();
        for (int i = 0; i < 10; i++) begin
            drive(1'b1, 1'b0, 1'b0, 1'b1, PC_BR, 16'h8, '0, '0);
            chk_mealy("halted", 1'b0, PC_NPC, 1'b0, 1'b0);
            chk("halted.halted", 32'(bus.halted), 32'h1);
            tick();
        end
        chk("halted.fetch_cnt", 32'(bus.fetch_cnt), 32'd10);
        chk("halted.redir_cnt", 32'(bus.redir_cnt), 32'd3);

        nRST = 1'b0;
        drive(1'b0, 1'b0, 1'b0, 1'b0, PC_NPC, '0, '0, '0);
        tick();
        chk("rst2.halted",    32'(bus.halted),    32'h0);
        chk("rst2.fetch_cnt", 32'(bus.fetch_cnt), 32'h0);
        chk("rst2.redir_cnt", 32'(bus.redir_cnt), 32'h0);

        // Saturation of the 4-bit fetch counter
        nRST = 1'b1;
        for (int i = 0; i < 20; i++) begin
            drive(1'b1, 1'b0, 1'b0, 1'b0, PC_NPC, '0, '0, '0);
            if (i == 0) chk_mealy("sat_first", 1'b1, PC_NPC, 1'b0, 1'b1);
            tick();
            if (i == 14) chk("sat.fetch_cnt15", 32'(bus.fetch_cnt), 32'd15);
        end
        chk("sat.fetch_cnt20", 32'(bus.fetch_cnt), 32'd15);
        chk("sat.redir_cnt",   32'(bus.redir_cnt), 32'd0);

        // Reset while a redirect is pending discards it
        drive(1'b0, 1'b0, 1'b0, 1'b1, PC_JR, '0, '0, 32'h200);
        tick();
        nRST = 1'b0;
        drive(1'b0, 1'b0, 1'b0, 1'b0, PC_NPC, '0, '0, '0);
        tick();
        nRST = 1'b1;
        drive(1'b1, 1'b0, 1'b0, 1'b0, PC_NPC, '0, '0, '0);
        chk_mealy("rst_redir", 1'b1, PC_NPC, 1'b0, 1'b1);
        chk("rst_redir.jr", 32'(bus.jr), 32'h0);
        tick();
        chk("rst_redir.redir_cnt", 32'(bus.redir_cnt), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
